// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and owner ids.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug and memory-side signals around the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_wait;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_lock;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          owner;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, cpu_wait,
        output dbg_ack, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output owner
    );

    // Requesters and memory side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, cpu_wait,
        input  dbg_ack, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  owner
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way grant decision: round-robin on a tie unless the debug lock forces debug.
module rr_pick2
    import dmem_pkg::*;
(
    input  logic req_cpu_i,
    input  logic req_dbg_i,
    input  logic last_owner_i,
    input  logic lock_i,
    output logic grant_valid_o,
    output logic grant_id_o
);

    always_comb begin
        grant_valid_o = req_cpu_i | req_dbg_i;
        grant_id_o    = OWN_CPU;
        if (req_cpu_i && req_dbg_i) begin
            grant_id_o = lock_i ? OWN_DBG : ~last_owner_i;
        end else if (req_dbg_i) begin
            grant_id_o = OWN_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and the debug/loader port.
// Each grant runs IDLE -> ACCESS -> CAPTURE -> DONE; everything but cpu_wait is registered.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input logic            clk,
    input logic            rst,
    dmem_arbiter_if.slave  bus
);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dbg_ack_q, dbg_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

    logic grant_valid;
    logic grant_id;

    rr_pick2 u_pick (
        .req_cpu_i     (bus.cpu_req),
        .req_dbg_i     (bus.dbg_req),
        .last_owner_i  (owner_q),
        .lock_i        (bus.dbg_lock),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_id;
                    if (grant_id == OWN_DBG) begin
                        we_d    = bus.dbg_we;
                        addr_d  = bus.dbg_addr;
                        wdata_d = bus.dbg_wdata;
                    end else begin
                        we_d    = bus.cpu_we;
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                    end
                    // Strobes are registered, so they are raised here to appear in ACCESS.
                    mem_en_d = 1'b1;
                    mem_we_d = we_d;
                    state_d  = ACCESS;
                end
            end
            ACCESS: state_d = CAPTURE;
            CAPTURE: begin
                if (!we_q) begin
                    if (owner_q == OWN_DBG) dbg_rdata_d = bus.mem_rdata;
                    else                    cpu_rdata_d = bus.mem_rdata;
                end
                if (owner_q == OWN_DBG) dbg_ack_d = 1'b1;
                else                    cpu_ack_d = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_DBG;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.owner     = owner_q;
    assign bus.cpu_wait  = bus.cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected memory accesses and acks are queued in
// service order; a negedge monitor pops and compares them as the DUT presents them.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(4), .DW(8)) bus ();

    dmem_arbiter #(.AW(4), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural 16x8 memory with synchronous read.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [7:0] wdata;
    } acc_t;

    typedef struct {
        bit         port;
        logic [7:0] cpu_rd;
        logic [7:0] dbg_rd;
    } ack_t;

    acc_t acc_q[$];
    ack_t ack_q[$];
    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_cpu_rd = 8'h00;
    logic [7:0] exp_dbg_rd = 8'h00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic exp_push(input bit port, input bit we, input logic [3:0] a,
                            input logic [7:0] wd, input logic [7:0] rd);
        acc_t acc;
        ack_t ack;
        acc.we = we; acc.addr = a; acc.wdata = wd;
        acc_q.push_back(acc);
        if (!we) begin
            if (port) exp_dbg_rd = rd;
            else      exp_cpu_rd = rd;
        end
        ack.port = port; ack.cpu_rd = exp_cpu_rd; ack.dbg_rd = exp_dbg_rd;
        ack_q.push_back(ack);
    endtask

    // Monitor: compares every memory strobe and every ack against the queues.
    always @(negedge clk) begin
        acc_t acc;
        ack_t ack;
        if (bus.mem_en === 1'b1) begin
            if (acc_q.size() == 0) begin
                chk("unexpected_mem_en", 32'd1, 32'd0);
            end else begin
                acc = acc_q.pop_front();
                chk("mem_we", {31'd0, bus.mem_we}, {31'd0, acc.we});
                chk("mem_addr", {28'd0, bus.mem_addr}, {28'd0, acc.addr});
                if (acc.we) chk("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, acc.wdata});
            end
        end
        if (bus.cpu_ack === 1'b1 || bus.dbg_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", {30'd0, bus.dbg_ack, bus.cpu_ack}, 32'd0);
            end else begin
                ack = ack_q.pop_front();
                chk("ack_port", {30'd0, bus.dbg_ack, bus.cpu_ack},
                    ack.port ? 32'd2 : 32'd1);
                chk("owner_at_ack", {31'd0, bus.owner}, {31'd0, ack.port});
                chk("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, ack.cpu_rd});
                chk("dbg_rdata", {24'd0, bus.dbg_rdata}, {24'd0, ack.dbg_rd});
            end
        end
    end

    task automatic drive(input bit port, input logic req, input logic we,
                         input logic [3:0] a, input logic [7:0] wd);
        if (port) begin
            bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = wd;
        end else begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
        end
    endtask

    // Raise req at a negedge, wait (bounded) for ack, drop req just after the sampling edge.
    task automatic access(input bit port, input bit we, input logic [3:0] a,
                          input logic [7:0] wd, output int lat);
        bit seen = 1'b0;
        lat = -1;
        @(negedge clk);
        drive(port, 1'b1, we, a, wd);
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if ((port ? bus.dbg_ack : bus.cpu_ack) === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                if (!port) chk("cpu_wait_at_ack", {31'd0, bus.cpu_wait}, 32'd0);
            end else if (!port) begin
                chk("cpu_wait_stall", {31'd0, bus.cpu_wait}, 32'd1);
            end
        end
        if (!seen) chk(port ? "dbg_ack_timeout" : "cpu_ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        drive(port, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_acks", {30'd0, bus.dbg_ack, bus.cpu_ack}, 32'd0);
        chk("rst_owner", {31'd0, bus.owner}, 32'd1);
        chk("rst_rdata", {bus.cpu_rdata, bus.dbg_rdata}, 32'd0);
        chk("rst_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 32'd0);
        exp_cpu_rd = 8'h00;
        exp_dbg_rd = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int l0, l1, l2;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        bus.dbg_lock = 1'b0;
        repeat (2) @(posedge clk);

        // Mid-cycle reset, then idle cycles with no strobes.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_mem_en", {31'd0, bus.mem_en}, 32'd0);
        end

        // Tie from reset: CPU first, debug one full access later.
        exp_push(1'b0, 1'b1, 4'd5, 8'h55, 8'h00);
        exp_push(1'b1, 1'b1, 4'd6, 8'h66, 8'h00);
        fork
            access(1'b0, 1'b1, 4'd5, 8'h55, l0);
            access(1'b1, 1'b1, 4'd6, 8'h66, l1);
        join
        chk("tie1_cpu_lat", l0, 32'd3);
        chk("tie1_dbg_lat", l1, 32'd7);

        // Debug write addr 3, then CPU reads it back.
        exp_push(1'b1, 1'b1, 4'd3, 8'h02, 8'h00);
        access(1'b1, 1'b1, 4'd3, 8'h02, l0);
        chk("dbg_wr_lat", l0, 32'd3);
        chk("dbg_ack_one_cycle", {31'd0, bus.dbg_ack}, 32'd0);
        exp_push(1'b0, 1'b0, 4'd3, 8'h00, 8'h02);
        access(1'b0, 1'b0, 4'd3, 8'h00, l0);
        chk("cpu_rd_lat", l0, 32'd3);

        // Last owner is CPU: the tie now goes to debug.
        exp_push(1'b1, 1'b0, 4'd5, 8'h00, 8'h55);
        exp_push(1'b0, 1'b0, 4'd6, 8'h00, 8'h66);
        fork
            access(1'b0, 1'b0, 4'd6, 8'h00, l0);
            access(1'b1, 1'b0, 4'd5, 8'h00, l1);
        join
        chk("tie2_cpu_lat", l0, 32'd7);
        chk("tie2_dbg_lat", l1, 32'd3);

        // Make debug the last owner, then lock: debug still wins twice in a row.
        exp_push(1'b1, 1'b1, 4'd9, 8'h99, 8'h00);
        access(1'b1, 1'b1, 4'd9, 8'h99, l0);
        bus.dbg_lock = 1'b1;
        exp_push(1'b1, 1'b1, 4'd8, 8'h88, 8'h00);
        exp_push(1'b1, 1'b0, 4'd8, 8'h00, 8'h88);
        exp_push(1'b0, 1'b0, 4'd5, 8'h00, 8'h55);
        fork
            access(1'b0, 1'b0, 4'd5, 8'h00, l0);
            begin
                access(1'b1, 1'b1, 4'd8, 8'h88, l1);
                access(1'b1, 1'b0, 4'd8, 8'h00, l2);
            end
        join
        bus.dbg_lock = 1'b0;
        chk("lock_cpu_lat", l0, 32'd11);
        chk("lock_dbg1_lat", l1, 32'd3);
        chk("lock_dbg2_lat", l2, 32'd3);

        // Top address: write then read 15.
        exp_push(1'b0, 1'b1, 4'd15, 8'hFF, 8'h00);
        access(1'b0, 1'b1, 4'd15, 8'hFF, l0);
        exp_push(1'b0, 1'b0, 4'd15, 8'h00, 8'hFF);
        access(1'b0, 1'b0, 4'd15, 8'h00, l0);
        chk("addr15_rd_lat", l0, 32'd3);

        // Reset in the ACCESS cycle of a CPU write: strobe drops, no ack follows.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 4'd10, 8'hAA);
        begin
            acc_t acc;
            acc.we = 1'b1; acc.addr = 4'd10; acc.wdata = 8'hAA;
            acc_q.push_back(acc);
        end
        @(negedge clk);
        chk("abort_mem_en_before", {31'd0, bus.mem_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("abort_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
        chk("abort_owner", {31'd0, bus.owner}, 32'd1);
        exp_cpu_rd = 8'h00;
        exp_dbg_rd = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_abort_idle", {30'd0, bus.mem_en, bus.cpu_ack}, 32'd0);
        end

        // After reset the next tie goes to the CPU again.
        exp_push(1'b0, 1'b0, 4'd15, 8'h00, 8'hFF);
        exp_push(1'b1, 1'b0, 4'd6, 8'h00, 8'h66);
        fork
            access(1'b0, 1'b0, 4'd15, 8'h00, l0);
            access(1'b1, 1'b0, 4'd6, 8'h00, l1);
        join
        chk("tie3_cpu_lat", l0, 32'd3);
        chk("tie3_dbg_lat", l1, 32'd7);

        repeat (3) @(negedge clk);
        chk("acc_q_drained", acc_q.size(), 32'd0);
        chk("ack_q_drained", ack_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
